// File: rtl/idct_pkg.sv
// ---------------------------------------------------------------------------
// idct_pkg
// Shared definitions for the IDCT vector-rotation read controller.
//   FFTPTS_W   : width of the frame-length field (fftpts_in / fftpts_out)
//   N_MIN/N_MAX: smallest and largest legal frame length
//   state_t    : controller FSM state encoding
//   n_is_legal : true when N is a power of two inside [N_MIN, N_MAX]
// ---------------------------------------------------------------------------
package idct_pkg;

  localparam int FFTPTS_W = 12;
  localparam int N_MIN    = 4;
  localparam int N_MAX    = 2048;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic n_is_legal(input logic [FFTPTS_W-1:0] n);
    logic [FFTPTS_W-1:0] nm1;
    nm1 = n - FFTPTS_W'(1);
    return (n >= FFTPTS_W'(N_MIN)) && (n <= FFTPTS_W'(N_MAX)) && ((n & nm1) == '0);
  endfunction

endpackage

// File: rtl/idct_vecrot_ctrl_skid.sv
// ---------------------------------------------------------------------------
// idct_vecrot_ctrl_skid
// Two-entry FIFO between the frame-buffer read port and the streaming output.
// Ports:
//   clk, srst : clock and synchronous active-high reset (empties the FIFO)
//   push, din : write one entry (caller guarantees the FIFO is not full)
//   pop       : consume the head entry (ignored when empty)
//   dout      : head entry, valid while valid=1
//   valid     : FIFO non-empty
//   count     : current occupancy, 0..2
// ---------------------------------------------------------------------------
module idct_vecrot_ctrl_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_pop;

  assign do_pop = pop && (count_q != 2'd0);

  always_ff @(posedge clk) begin
    if (srst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      // push and pop in the same cycle cancel out
      count_q <= count_q + 2'(push) - 2'(do_pop);
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/idct_vecrot_ctrl.sv
// ---------------------------------------------------------------------------
// idct_vecrot_ctrl
// Reads a frame of N complex samples from a dual-port frame buffer as pairs
// D(k) / D((N-k) mod N) and streams them out over an Avalon-ST style
// valid/ready interface with sop/eop framing.
// Ports:
//   clk, rst_sync          : clock, synchronous active-high reset
//   start, fftpts_in       : frame request and frame length N (sampled in IDLE)
//   busy, done, cfg_err    : status (busy in RUN/DRAIN, done after eop, bad N)
//   rd_en, rd_addr_fwd/rev : frame-buffer read strobe and the two addresses
//   rd_*_fwd/rev           : read data, valid one clock after rd_en
//   src_valid/ready/sop/eop: output handshake and framing
//   src_real/imag(_rev)    : paired output samples
//   fftpts_out             : N latched at start
// Build option: define IDCT_VECROT_CTRL_CHK_EN to reject illegal N with a
// one-clock cfg_err pulse; otherwise cfg_err is tied low and N is unchecked.
// ---------------------------------------------------------------------------
module idct_vecrot_ctrl
  import idct_pkg::*;
#(
  parameter int wData = 24,
  parameter int wAddr = 11
) (
  input  logic                clk,
  input  logic                rst_sync,
  input  logic                start,
  input  logic [FFTPTS_W-1:0] fftpts_in,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic                rd_en,
  output logic [wAddr-1:0]    rd_addr_fwd,
  output logic [wAddr-1:0]    rd_addr_rev,
  input  logic [wData-1:0]    rd_real_fwd,
  input  logic [wData-1:0]    rd_imag_fwd,
  input  logic [wData-1:0]    rd_real_rev,
  input  logic [wData-1:0]    rd_imag_rev,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                src_sop,
  output logic                src_eop,
  output logic [wData-1:0]    src_real,
  output logic [wData-1:0]    src_imag,
  output logic [wData-1:0]    src_real_rev,
  output logic [wData-1:0]    src_imag_rev,
  output logic [FFTPTS_W-1:0] fftpts_out
);

  localparam int PW = 4 * wData + 2;

  state_t              state_q;
  logic [wAddr-1:0]    k_q;
  logic [FFTPTS_W-1:0] n_q;
  logic                done_q;
  // read issued last cycle: its data is on rd_* now and is pushed this cycle
  logic                rdv_q;
  logic                rd_sop_q;
  logic                rd_eop_q;
`ifdef IDCT_VECROT_CTRL_CHK_EN
  logic                cfg_err_q;
`endif

  logic [wAddr-1:0]    mask;
  logic                last_k;
  logic                start_ok;
  logic [1:0]          fifo_cnt;
  logic                fifo_valid;
  logic                pop;
  logic [2:0]          occ;
  logic                rd_issue;
  logic [PW-1:0]       fifo_din;
  logic [PW-1:0]       head;

  assign mask   = wAddr'(n_q - FFTPTS_W'(1));
  assign last_k = (k_q == mask);
  assign pop    = fifo_valid & src_ready;

  // In-flight read plus FIFO occupancy, less the beat leaving this cycle.
  // Crediting the pop keeps a full 1 beat/clk stream while src_ready stays
  // high, and the FIFO still never exceeds two entries.
  assign occ      = 3'(rdv_q) + 3'(fifo_cnt) - 3'(pop);
  assign rd_issue = (state_q == ST_RUN) && (occ < 3'd2);

`ifdef IDCT_VECROT_CTRL_CHK_EN
  assign start_ok = n_is_legal(fftpts_in);
  assign cfg_err  = cfg_err_q;
`else
  assign start_ok = 1'b1;
  assign cfg_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      n_q       <= '0;
      done_q    <= 1'b0;
      rdv_q     <= 1'b0;
      rd_sop_q  <= 1'b0;
      rd_eop_q  <= 1'b0;
`ifdef IDCT_VECROT_CTRL_CHK_EN
      cfg_err_q <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
`ifdef IDCT_VECROT_CTRL_CHK_EN
      cfg_err_q <= 1'b0;
`endif
      // framing tags travel alongside the read so they land with the data
      rdv_q    <= rd_issue;
      rd_sop_q <= rd_issue && (k_q == '0);
      rd_eop_q <= rd_issue && last_k;
      case (state_q)
        ST_IDLE: begin
          if (start && start_ok) begin
            state_q <= ST_RUN;
            n_q     <= fftpts_in;
            k_q     <= '0;
          end
`ifdef IDCT_VECROT_CTRL_CHK_EN
          if (start && !start_ok) begin
            cfg_err_q <= 1'b1;
          end
`endif
        end
        ST_RUN: begin
          if (rd_issue) begin
            k_q <= k_q + wAddr'(1);
            if (last_k) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && src_eop) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_din = {rd_eop_q, rd_sop_q, rd_real_fwd, rd_imag_fwd, rd_real_rev, rd_imag_rev};

  idct_vecrot_ctrl_skid #(
    .W(PW)
  ) u_skid (
    .clk  (clk),
    .srst (rst_sync),
    .push (rdv_q),
    .din  (fifo_din),
    .pop  (pop),
    .dout (head),
    .valid(fifo_valid),
    .count(fifo_cnt)
  );

  assign {src_eop, src_sop, src_real, src_imag, src_real_rev, src_imag_rev} = head;

  assign src_valid   = fifo_valid;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign rd_en       = rd_issue;
  assign rd_addr_fwd = k_q;
  // (N-k) mod N; k=0 wraps to 0
  assign rd_addr_rev = (~k_q + wAddr'(1)) & mask;
  assign fftpts_out  = n_q;

endmodule
